// File: rtl/scpad_tile_sequencer.sv
// Tile sequencer for the scratchpad swizzle path.
// Two requesters (0 = vector side, 1 = DMA side) share the swizzle unit. A
// round-robin arbiter accepts one tile descriptor at a time; the tile is then
// streamed as one beat per row (row-major) or per column (column-major) under
// a valid/ready handshake, and completion is reported with a one-cycle pulse.
module scpad_tile_sequencer #(
    parameter int NUM_COLS      = 32,
    parameter int COL_IDX_WIDTH = $clog2(NUM_COLS),
    parameter int ROW_IDX_WIDTH = 8,
    parameter int ID_WIDTH      = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_row_or_col,
    input  logic [1:0]                 req_write,
    input  logic [2*ROW_IDX_WIDTH-1:0] req_spad_addr,
    input  logic [2*COL_IDX_WIDTH-1:0] req_num_rows,
    input  logic [2*COL_IDX_WIDTH-1:0] req_num_cols,
    input  logic [2*ID_WIDTH-1:0]      req_id,
    output logic                       sw_valid,
    input  logic                       sw_ready,
    output logic                       sw_row_or_col,
    output logic                       sw_write,
    output logic [ROW_IDX_WIDTH-1:0]   sw_spad_addr,
    output logic [COL_IDX_WIDTH-1:0]   sw_row_id,
    output logic [COL_IDX_WIDTH-1:0]   sw_col_id,
    output logic [COL_IDX_WIDTH-1:0]   sw_num_rows,
    output logic [COL_IDX_WIDTH-1:0]   sw_num_cols,
    output logic                       sw_last,
    output logic                       sw_src,
    output logic [ID_WIDTH-1:0]        sw_id,
    output logic                       done,
    output logic                       done_src,
    output logic [ID_WIDTH-1:0]        done_id,
    output logic                       busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    localparam logic [COL_IDX_WIDTH-1:0] CNT_ONE = COL_IDX_WIDTH'(1);

    state_t                     state_q, state_d;

    // Last granted requester; resets to 1 so requester 0 wins the first tie.
    logic                       last_gnt_q, last_gnt_d;
    logic [COL_IDX_WIDTH-1:0]   cnt_q, cnt_d;
    logic                       row_or_col_q, row_or_col_d;
    logic                       write_q, write_d;
    logic [ROW_IDX_WIDTH-1:0]   spad_addr_q, spad_addr_d;
    logic [COL_IDX_WIDTH-1:0]   num_rows_q, num_rows_d;
    logic [COL_IDX_WIDTH-1:0]   num_cols_q, num_cols_d;
    logic                       src_q, src_d;
    logic [ID_WIDTH-1:0]        id_q, id_d;
    logic                       done_q, done_d;
    logic                       done_src_q, done_src_d;
    logic [ID_WIDTH-1:0]        done_id_q, done_id_d;

    logic                       gnt_any_s;
    logic                       gnt_sel_s;
    logic [COL_IDX_WIDTH-1:0]   extent_s;
    logic                       last_beat_s;
    logic                       beat_hs_s;

    // Round-robin pick among valid requesters; only meaningful in IDLE.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_sel_s = 1'b0;
        if (state_q == ST_IDLE) begin
            case (req_valid)
                2'b01: begin
                    gnt_any_s = 1'b1;
                    gnt_sel_s = 1'b0;
                end
                2'b10: begin
                    gnt_any_s = 1'b1;
                    gnt_sel_s = 1'b1;
                end
                2'b11: begin
                    gnt_any_s = 1'b1;
                    gnt_sel_s = ~last_gnt_q;
                end
                default: begin
                    gnt_any_s = 1'b0;
                    gnt_sel_s = 1'b0;
                end
            endcase
        end else begin
            gnt_any_s = 1'b0;
            gnt_sel_s = 1'b0;
        end
    end

    // Beat bookkeeping: active extent depends on tile orientation.
    always_comb begin
        extent_s    = row_or_col_q ? num_rows_q : num_cols_q;
        last_beat_s = (cnt_q == extent_s);
        beat_hs_s   = (state_q == ST_ISSUE) && sw_ready;
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (beat_hs_s && last_beat_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; req_ready is held low while reset is asserted.
    always_comb begin
        busy     = (state_q == ST_ISSUE);
        sw_valid = (state_q == ST_ISSUE);
        sw_last  = (state_q == ST_ISSUE) && last_beat_s;
        if (gnt_any_s && nRST) begin
            req_ready = gnt_sel_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Descriptor latch, beat counter and completion report next values.
    always_comb begin
        last_gnt_d   = last_gnt_q;
        cnt_d        = cnt_q;
        row_or_col_d = row_or_col_q;
        write_d      = write_q;
        spad_addr_d  = spad_addr_q;
        num_rows_d   = num_rows_q;
        num_cols_d   = num_cols_q;
        src_d        = src_q;
        id_d         = id_q;
        done_d       = 1'b0;
        done_src_d   = done_src_q;
        done_id_d    = done_id_q;
        if (gnt_any_s) begin
            last_gnt_d   = gnt_sel_s;
            cnt_d        = '0;
            src_d        = gnt_sel_s;
            row_or_col_d = gnt_sel_s ? req_row_or_col[1] : req_row_or_col[0];
            write_d      = gnt_sel_s ? req_write[1] : req_write[0];
            spad_addr_d  = gnt_sel_s ? req_spad_addr[2*ROW_IDX_WIDTH-1:ROW_IDX_WIDTH]
                                     : req_spad_addr[ROW_IDX_WIDTH-1:0];
            num_rows_d   = gnt_sel_s ? req_num_rows[2*COL_IDX_WIDTH-1:COL_IDX_WIDTH]
                                     : req_num_rows[COL_IDX_WIDTH-1:0];
            num_cols_d   = gnt_sel_s ? req_num_cols[2*COL_IDX_WIDTH-1:COL_IDX_WIDTH]
                                     : req_num_cols[COL_IDX_WIDTH-1:0];
            id_d         = gnt_sel_s ? req_id[2*ID_WIDTH-1:ID_WIDTH]
                                     : req_id[ID_WIDTH-1:0];
        end else if (beat_hs_s) begin
            if (last_beat_s) begin
                // Counter is left at the extent; it is cleared on the next grant.
                done_d     = 1'b1;
                done_src_d = src_q;
                done_id_d  = id_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers; reset discards any tile in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_gnt_q   <= 1'b1;
            cnt_q        <= '0;
            row_or_col_q <= 1'b0;
            write_q      <= 1'b0;
            spad_addr_q  <= '0;
            num_rows_q   <= '0;
            num_cols_q   <= '0;
            src_q        <= 1'b0;
            id_q         <= '0;
            done_q       <= 1'b0;
            done_src_q   <= 1'b0;
            done_id_q    <= '0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            cnt_q        <= cnt_d;
            row_or_col_q <= row_or_col_d;
            write_q      <= write_d;
            spad_addr_q  <= spad_addr_d;
            num_rows_q   <= num_rows_d;
            num_cols_q   <= num_cols_d;
            src_q        <= src_d;
            id_q         <= id_d;
            done_q       <= done_d;
            done_src_q   <= done_src_d;
            done_id_q    <= done_id_d;
        end
    end

    // Beat fields straight from the latched descriptor and counter.
    always_comb begin
        sw_row_or_col = row_or_col_q;
        sw_write      = write_q;
        sw_spad_addr  = spad_addr_q;
        sw_num_rows   = num_rows_q;
        sw_num_cols   = num_cols_q;
        sw_src        = src_q;
        sw_id         = id_q;
        sw_row_id     = row_or_col_q ? cnt_q : '0;
        sw_col_id     = row_or_col_q ? '0 : cnt_q;
        done          = done_q;
        done_src      = done_src_q;
        done_id       = done_id_q;
    end

endmodule

// File: tb/tb_scpad_tile_sequencer.sv
// Directed bench for scpad_tile_sequencer: every scenario drives inputs on
// the falling edge and checks outputs there against hand-computed values.
module tb_scpad_tile_sequencer;

    localparam int CW = 5;
    localparam int AW = 8;
    localparam int IW = 4;

    logic          CLK;
    logic          nRST;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_row_or_col;
    logic [1:0]    req_write;
    logic [2*AW-1:0] req_spad_addr;
    logic [2*CW-1:0] req_num_rows;
    logic [2*CW-1:0] req_num_cols;
    logic [2*IW-1:0] req_id;
    logic          sw_valid;
    logic          sw_ready;
    logic          sw_row_or_col;
    logic          sw_write;
    logic [AW-1:0] sw_spad_addr;
    logic [CW-1:0] sw_row_id;
    logic [CW-1:0] sw_col_id;
    logic [CW-1:0] sw_num_rows;
    logic [CW-1:0] sw_num_cols;
    logic          sw_last;
    logic          sw_src;
    logic [IW-1:0] sw_id;
    logic          done;
    logic          done_src;
    logic [IW-1:0] done_id;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    scpad_tile_sequencer dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_row_or_col(req_row_or_col), .req_write(req_write),
        .req_spad_addr(req_spad_addr), .req_num_rows(req_num_rows),
        .req_num_cols(req_num_cols), .req_id(req_id),
        .sw_valid(sw_valid), .sw_ready(sw_ready),
        .sw_row_or_col(sw_row_or_col), .sw_write(sw_write),
        .sw_spad_addr(sw_spad_addr), .sw_row_id(sw_row_id),
        .sw_col_id(sw_col_id), .sw_num_rows(sw_num_rows),
        .sw_num_cols(sw_num_cols), .sw_last(sw_last),
        .sw_src(sw_src), .sw_id(sw_id),
        .done(done), .done_src(done_src), .done_id(done_id), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic drive_req(input int i, input logic v, input logic roc, input logic wr,
                             input logic [AW-1:0] addr, input logic [CW-1:0] nr,
                             input logic [CW-1:0] nc, input logic [IW-1:0] id);
        req_valid[i]            = v;
        req_row_or_col[i]       = roc;
        req_write[i]            = wr;
        req_spad_addr[i*AW +: AW] = addr;
        req_num_rows[i*CW +: CW]  = nr;
        req_num_cols[i*CW +: CW]  = nc;
        req_id[i*IW +: IW]        = id;
    endtask

    task automatic test_reset();
        nRST = 1'b0; req_valid = 2'b11; sw_ready = 1'b1;
        req_row_or_col = 2'b11; req_write = 2'b11;
        req_spad_addr = '1; req_num_rows = '1; req_num_cols = '1; req_id = '1;
        @(negedge CLK); #1;
        n_cmp++;
        if ({req_ready, sw_valid, busy, done, sw_last, sw_row_id, sw_col_id, sw_spad_addr, sw_id, done_id, done_src, sw_src}
            !== {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b v=%b busy=%b done=%b last=%b row=%0d col=%0d addr=%h id=%h expected all zero",
                     req_ready, sw_valid, busy, done, sw_last, sw_row_id, sw_col_id, sw_spad_addr, sw_id);
        end
        req_valid = 2'b00;
        @(negedge CLK); nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_row_major();
        drive_req(0, 1'b1, 1'b1, 1'b0, 8'h10, 5'd3, 5'd31, 4'h5);
        sw_ready = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, sw_valid} !== {2'b01, 1'b0}) begin
            n_err++; $display("FAIL row_grant: got rdy=%b v=%b expected rdy=01 v=0", req_ready, sw_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (k == 0) req_valid = 2'b00;
            #1;
            n_cmp++;
            if ({sw_valid, busy, sw_row_id, sw_col_id, sw_last, sw_spad_addr, sw_num_rows, sw_num_cols, sw_src, sw_id, sw_write, sw_row_or_col, req_ready}
                !== {1'b1, 1'b1, CW'(k), 5'd0, (k == 3), 8'h10, 5'd3, 5'd31, 1'b0, 4'h5, 1'b0, 1'b1, 2'b00}) begin
                n_err++;
                $display("FAIL row_beat%0d: got v=%b row=%0d col=%0d last=%b addr=%h nr=%0d nc=%0d src=%b id=%h expected row=%0d last=%b",
                         k, sw_valid, sw_row_id, sw_col_id, sw_last, sw_spad_addr, sw_num_rows, sw_num_cols, sw_src, sw_id, k, (k == 3));
            end
        end
        @(negedge CLK); #1;
        n_cmp++;
        if ({sw_valid, busy, done, done_src, done_id} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'h5}) begin
            n_err++; $display("FAIL row_done: got v=%b busy=%b done=%b src=%b id=%h expected 0 0 1 0 5", sw_valid, busy, done, done_src, done_id);
        end
        @(negedge CLK); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL row_done_pulse: got done=%b expected 0", done);
        end
    endtask

    task automatic test_col_stall();
        logic [CW-1:0] exp_col;
        int hs;
        logic tog;
        exp_col = '0; hs = 0; tog = 1'b1;
        drive_req(1, 1'b1, 1'b0, 1'b1, 8'h80, 5'd2, 5'd5, 4'h9);
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL col_grant: got rdy=%b expected 10", req_ready);
        end
        @(negedge CLK);
        req_valid = 2'b00;
        for (int c = 0; c < 40 && hs < 6; c++) begin
            #1;
            n_cmp++;
            if ({sw_valid, busy, sw_row_id, sw_col_id, sw_last, sw_spad_addr, sw_num_rows, sw_num_cols, sw_src, sw_id, sw_write, sw_row_or_col}
                !== {1'b1, 1'b1, 5'd0, exp_col, (exp_col == 5'd5), 8'h80, 5'd2, 5'd5, 1'b1, 4'h9, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL col_beat_c%0d: got v=%b row=%0d col=%0d last=%b addr=%h src=%b id=%h wr=%b expected col=%0d",
                         c, sw_valid, sw_row_id, sw_col_id, sw_last, sw_spad_addr, sw_src, sw_id, sw_write, exp_col);
            end
            sw_ready = tog;
            if (tog) begin
                hs++;
                exp_col = exp_col + 5'd1;
            end
            tog = ~tog;
            @(negedge CLK);
        end
        sw_ready = 1'b1;
        #1;
        n_cmp++;
        if (hs !== 6) begin
            n_err++; $display("FAIL col_handshakes: got %0d expected 6", hs);
        end
        n_cmp++;
        if ({sw_valid, done, done_src, done_id} !== {1'b0, 1'b1, 1'b1, 4'h9}) begin
            n_err++; $display("FAIL col_done: got v=%b done=%b src=%b id=%h expected 0 1 1 9", sw_valid, done, done_src, done_id);
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        logic src;
        drive_req(0, 1'b1, 1'b1, 1'b0, 8'h20, 5'd0, 5'd0, 4'h3);
        drive_req(1, 1'b1, 1'b1, 1'b0, 8'h30, 5'd0, 5'd0, 4'hC);
        sw_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            src = t[0];
            #1;
            n_cmp++;
            if ({req_ready, sw_valid} !== {(src ? 2'b10 : 2'b01), 1'b0}) begin
                n_err++; $display("FAIL b2b_grant%0d: got rdy=%b v=%b expected src %0d", t, req_ready, sw_valid, src);
            end
            if (t > 0) begin
                n_cmp++;
                if ({done, done_src} !== {1'b1, ~src}) begin
                    n_err++; $display("FAIL b2b_done%0d: got done=%b src=%b expected 1 %b", t, done, done_src, ~src);
                end
            end
            @(negedge CLK); #1;
            n_cmp++;
            if ({sw_valid, sw_last, sw_src, sw_id, req_ready} !== {1'b1, 1'b1, src, (src ? 4'hC : 4'h3), 2'b00}) begin
                n_err++; $display("FAIL b2b_beat%0d: got v=%b last=%b src=%b id=%h rdy=%b expected src %b", t, sw_valid, sw_last, sw_src, sw_id, req_ready, src);
            end
            @(negedge CLK);
        end
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if ({sw_valid, done, done_src, done_id} !== {1'b0, 1'b1, 1'b1, 4'hC}) begin
            n_err++; $display("FAIL b2b_final_done: got v=%b done=%b src=%b id=%h expected 0 1 1 c", sw_valid, done, done_src, done_id);
        end
        @(negedge CLK);
    endtask

    task automatic test_extents();
        drive_req(0, 1'b1, 1'b1, 1'b0, 8'hF0, 5'd31, 5'd7, 4'h1);
        sw_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL ext_grant: got rdy=%b expected 01", req_ready);
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge CLK);
            if (k == 0) req_valid = 2'b00;
            #1;
            n_cmp++;
            if ({sw_valid, sw_row_id, sw_col_id, sw_last} !== {1'b1, CW'(k), 5'd0, (k == 31)}) begin
                n_err++; $display("FAIL ext_beat%0d: got v=%b row=%0d col=%0d last=%b expected row=%0d", k, sw_valid, sw_row_id, sw_col_id, sw_last, k);
            end
        end
        @(negedge CLK); #1;
        n_cmp++;
        if ({sw_valid, done, done_id} !== {1'b0, 1'b1, 4'h1}) begin
            n_err++; $display("FAIL ext_done32: got v=%b done=%b id=%h expected 0 1 1", sw_valid, done, done_id);
        end
        drive_req(1, 1'b1, 1'b0, 1'b0, 8'h44, 5'd7, 5'd0, 4'h2);
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_err++; $display("FAIL ext_grant1: got rdy=%b expected 10", req_ready);
        end
        @(negedge CLK);
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if ({sw_valid, sw_row_id, sw_col_id, sw_last, sw_num_rows, sw_num_cols} !== {1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 5'd0}) begin
            n_err++; $display("FAIL ext_single: got v=%b row=%0d col=%0d last=%b nr=%0d nc=%0d expected 1 0 0 1 7 0",
                              sw_valid, sw_row_id, sw_col_id, sw_last, sw_num_rows, sw_num_cols);
        end
        @(negedge CLK); #1;
        n_cmp++;
        if ({sw_valid, done, done_src, done_id} !== {1'b0, 1'b1, 1'b1, 4'h2}) begin
            n_err++; $display("FAIL ext_done1: got v=%b done=%b src=%b id=%h expected 0 1 1 2", sw_valid, done, done_src, done_id);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_tile();
        drive_req(0, 1'b1, 1'b1, 1'b0, 8'h55, 5'd9, 5'd3, 4'h6);
        sw_ready = 1'b1;
        @(negedge CLK);
        req_valid = 2'b00;
        @(negedge CLK);
        @(negedge CLK); #1;
        n_cmp++;
        if ({sw_valid, sw_row_id} !== {1'b1, 5'd2}) begin
            n_err++; $display("FAIL rst_pre: got v=%b row=%0d expected 1 2", sw_valid, sw_row_id);
        end
        nRST = 1'b0;
        #1;
        n_cmp++;
        if ({sw_valid, busy, done, req_ready, sw_last, sw_row_id, sw_spad_addr, sw_id, done_id} !== {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h00, 4'h0, 4'h0}) begin
            n_err++; $display("FAIL rst_async: got v=%b busy=%b done=%b row=%0d addr=%h expected zeros", sw_valid, busy, done, sw_row_id, sw_spad_addr);
        end
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK); #1;
            n_cmp++;
            if ({done, sw_valid, busy} !== 3'b000) begin
                n_err++; $display("FAIL rst_no_done%0d: got done=%b v=%b busy=%b expected 000", c, done, sw_valid, busy);
            end
        end
        drive_req(0, 1'b1, 1'b1, 1'b0, 8'h01, 5'd0, 5'd0, 4'h4);
        drive_req(1, 1'b1, 1'b1, 1'b0, 8'h02, 5'd0, 5'd0, 4'hB);
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL rst_rr_ptr: got rdy=%b expected 01", req_ready);
        end
        @(negedge CLK);
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if ({sw_valid, sw_src, sw_id, sw_last} !== {1'b1, 1'b0, 4'h4, 1'b1}) begin
            n_err++; $display("FAIL rst_post_beat: got v=%b src=%b id=%h last=%b expected 1 0 4 1", sw_valid, sw_src, sw_id, sw_last);
        end
        @(negedge CLK); #1;
        n_cmp++;
        if ({done, done_src, done_id} !== {1'b1, 1'b0, 4'h4}) begin
            n_err++; $display("FAIL rst_post_done: got done=%b src=%b id=%h expected 1 0 4", done, done_src, done_id);
        end
        @(negedge CLK);
    endtask

    task automatic test_req_while_busy();
        drive_req(0, 1'b1, 1'b1, 1'b0, 8'h66, 5'd3, 5'd1, 4'h7);
        sw_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (k == 0) req_valid[0] = 1'b0;
            if (k == 1) drive_req(1, 1'b1, 1'b0, 1'b1, 8'h77, 5'd1, 5'd1, 4'hD);
            if (k == 3) req_valid[1] = 1'b0;
            #1;
            n_cmp++;
            if ({sw_valid, sw_src, sw_id, sw_row_id, req_ready} !== {1'b1, 1'b0, 4'h7, CW'(k), 2'b00}) begin
                n_err++; $display("FAIL busy_beat%0d: got v=%b src=%b id=%h row=%0d rdy=%b expected src 0 id 7 row %0d rdy 00",
                                  k, sw_valid, sw_src, sw_id, sw_row_id, req_ready, k);
            end
        end
        @(negedge CLK); #1;
        n_cmp++;
        if ({done, done_src, done_id} !== {1'b1, 1'b0, 4'h7}) begin
            n_err++; $display("FAIL busy_done: got done=%b src=%b id=%h expected 1 0 7", done, done_src, done_id);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK); #1;
            n_cmp++;
            if ({sw_valid, busy, req_ready} !== {1'b0, 1'b0, 2'b00}) begin
                n_err++; $display("FAIL busy_no_grant%0d: got v=%b busy=%b rdy=%b expected 0 0 00", c, sw_valid, busy, req_ready);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_row_major();
        test_col_stall();
        test_back_to_back();
        test_extents();
        test_reset_mid_tile();
        test_req_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scpad_tile_sequencer.md
Name: scpad_tile_sequencer

Overview:
- Sequences tile accesses for the scratchpad swizzle/crossbar path and shares it between two requesters.
  - Requester 0: vector-side port.
  - Requester 1: DMA-side port.
- Accepts one tile descriptor at a time via round-robin arbitration, then emits one swizzle beat per cycle under a valid/ready handshake.
  - Row-major tiles: one beat per row.
  - Column-major tiles: one beat per column.
- Sits between the scratchpad request front-end and the swizzle unit. Its beat fields drive the swizzle's row_or_col, spad_addr, row_id, col_id, num_rows and num_cols inputs directly.

Parameters:
- NUM_COLS, 32, number of banks (power of two, ≥2).
- COL_IDX_WIDTH, $clog2(NUM_COLS), width of bank/column index and of tile extents.
- ROW_IDX_WIDTH, 8, width of a scratchpad row address.
- ID_WIDTH, 4, requester transaction tag width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester descriptor valid.
- req_ready  out  2  per-requester descriptor accepted (grant).
- req_row_or_col  in  2  1 = row-major, 0 = column-major.
- req_write  in  2  1 = write access.
- req_spad_addr  in  2xROW_IDX_WIDTH  tile base row.
- req_num_rows  in  2xCOL_IDX_WIDTH  last row index (inclusive).
- req_num_cols  in  2xCOL_IDX_WIDTH  last column index (inclusive).
- req_id  in  2xID_WIDTH  tag.
- sw_valid  out  1  beat valid.
- sw_ready  in  1  downstream accepts beat.
- sw_row_or_col, sw_write  out  1 each.
- sw_spad_addr  out  ROW_IDX_WIDTH.
- sw_row_id, sw_col_id  out  COL_IDX_WIDTH each.
- sw_num_rows, sw_num_cols  out  COL_IDX_WIDTH each.
- sw_last  out  1  final beat of tile.
- sw_src  out  1  granted requester.
- sw_id  out  ID_WIDTH.
- done  out  1  one-cycle pulse after last beat handshake.
- done_src  out  1  requester that completed.
- done_id  out  ID_WIDTH  tag of completed tile.
- busy  out  1  tile in progress.

Behaviour:
- Reset:
  - All outputs are 0; state = IDLE.
  - Round-robin pointer is set so requester 0 wins the first simultaneous request.
  - Reset mid-tile discards the tile silently: no done pulse, and sw_valid drops immediately (async).
- States: IDLE, ISSUE.
- IDLE:
  - req_ready is combinational and is only ever asserted in IDLE, for the selected requester.
  - Single requester valid: it is granted.
  - Both requesters valid: grant goes to the one not granted last; the pointer updates on each grant.
  - On grant, the descriptor is latched and the beat counter is cleared. Next cycle: ISSUE, sw_valid = 1.
  - Tile latency: first beat is valid the cycle after the grant.
- ISSUE:
  - sw_valid stays 1, and all sw_* fields are held stable while sw_valid && !sw_ready.
  - Beat handshake = sw_valid && sw_ready. Each handshake increments the beat counter.
  - Row-major: sw_row_id = counter, sw_col_id = 0, beats = num_rows+1.
  - Column-major: sw_col_id = counter, sw_row_id = 0, beats = num_cols+1.
  - sw_spad_addr, sw_num_rows, sw_num_cols, sw_write, sw_src and sw_id are the latched descriptor values for the whole tile.
  - sw_last = 1 when counter equals the active extent.
  - Handshake on sw_last: next cycle is IDLE, sw_valid = 0, done = 1 with done_src/done_id. busy deasserts that same cycle.
  - A new grant may occur in that same IDLE cycle, so tiles are separated by exactly one bubble.
- Extents and counter:
  - Extent 0 → single-beat tile.
  - Extent NUM_COLS-1 → NUM_COLS beats, with the counter reaching its all-ones value without wrap.
  - The counter is COL_IDX_WIDTH wide; no arithmetic on spad_addr (swizzle performs base+offset with natural ROW_IDX_WIDTH wrap).
- Requester-side rules:
  - No grant while busy.
  - A requester deasserting req_valid before grant is legal and loses nothing.
  - A requester must hold its fields stable while valid and ungranted.
- busy = (state == ISSUE).

Test Plan:
- Req0 row-major, spad_addr=0x10, num_rows=3, num_cols=31, sw_ready=1 → grant cycle 0; beats cycles 1–4 with row_id 0,1,2,3, col_id 0, sw_last on row_id 3; done cycle 5 with done_src=0.
- Req1 column-major, num_cols=5, sw_ready toggling 1,0,1,0… → 6 handshakes, col_id 0..5; fields stable during stalls; sw_last only on col_id 5.
- Both valid every cycle for 4 tiles (num_rows=0, row-major) → grants alternate 0,1,0,1; each tile gives 1 beat, a done pulse, then one bubble.
- Extents num_rows=31 row-major and num_cols=0 column-major → 32 beats ending at row_id 31 with no wrap; then 1 beat with sw_last=1.
- nRST asserted at beat 2 of a 10-beat tile → sw_valid, busy and done are 0 immediately, no done pulse occurs; after release, req0 wins a simultaneous request.
- req_valid raised and dropped while busy → never granted, no beats emitted for it.
